// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the pipelined MIPS core.
package cpu_types_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned OPCODE_W = 6;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [OPCODE_W-1:0] HALT_OPCODE = 6'b111111;

    // Clear the byte offset so every fetch address is word aligned.
    function automatic word_t word_align(input word_t addr);
        return addr & ~word_t'(3);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to the icache and feeds IF/DC.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t                PC_INIT = 32'h0000_0000,
    parameter logic [OPCODE_W-1:0]  HALT_OP = HALT_OPCODE
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        iREN,
    output logic [31:0] imemaddr,
    output logic [31:0] npc_o,
    output logic [31:0] imemload_o,
    output logic        pipe_en,
    output logic        flush,
    output logic        halted,
    output logic [31:0] fetch_count
);

    fetch_state_t state;
    word_t        pc;
    word_t        tgt_r;
    word_t        count_r;
    word_t        pc_plus4;
    word_t        redirect_aligned;
    logic         accept;
    logic         is_halt;

    assign pc_plus4         = pc + word_t'(4);
    assign redirect_aligned = word_align(redirect_pc);
    assign is_halt          = (imemload[31:26] == HALT_OP);
    assign accept           = (state == FETCH) && ihit && !stall && !redirect_valid;

    // Control outputs: pipe_en/flush must follow this cycle's ihit and redirect,
    // and everything is quiet while reset is held.
    always_comb begin
        iREN       = 1'b0;
        pipe_en    = 1'b0;
        flush      = 1'b0;
        halted     = 1'b0;
        imemaddr   = pc;
        npc_o      = pc_plus4;
        imemload_o = imemload;
        fetch_count = count_r;
        if (nRST) begin
            iREN    = (state != HALTED);
            pipe_en = accept;
            flush   = redirect_valid;
            halted  = (state == HALTED);
        end
    end

    // PC, state, pending redirect target and accepted-instruction counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= FETCH;
            pc      <= PC_INIT;
            tgt_r   <= '0;
            count_r <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect_valid) begin
                        if (ihit) begin
                            pc <= redirect_aligned;
                        end else begin
                            // Miss outstanding: let the fill finish on the old address.
                            tgt_r <= redirect_aligned;
                            state <= DRAIN;
                        end
                    end else if (ihit && !stall) begin
                        pc      <= pc_plus4;
                        count_r <= count_r + word_t'(1);
                        if (is_halt) begin
                            state <= HALTED;
                        end
                    end
                end
                DRAIN: begin
                    if (ihit) begin
                        pc    <= redirect_valid ? redirect_aligned : tgt_r;
                        state <= FETCH;
                    end else if (redirect_valid) begin
                        tgt_r <= redirect_aligned;
                    end
                end
                HALTED: begin
                    if (redirect_valid) begin
                        pc    <= redirect_aligned;
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipelined MIPS core; the producer side of the IF/DC pipeline register.
- Owns the PC and issues word reads to the instruction cache/memory via an iREN/ihit handshake.
- Presents npc/instruction pairs to IF/DC with a per-cycle enable, and generates the IF/DC flush on control-flow redirects.
- Tracks redirects that arrive while an instruction miss is outstanding, and stops fetching after a HALT word.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded at reset
HALT_OP, 6'b111111, opcode field [31:26] identifying HALT

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
ihit  input  1  instruction memory returns valid word for imemaddr this cycle
imemload  input  32  instruction word, valid when ihit=1
stall  input  1  hazard unit: IF/DC must hold this cycle
redirect_valid  input  1  one-cycle pulse from EX/MEM: branch taken / jump / mispredict
redirect_pc  input  32  target PC, valid with redirect_valid
iREN  output  1  instruction read request
imemaddr  output  32  instruction address, word aligned
npc_o  output  32  pc+4 of delivered instruction, to IF/DC npc input
imemload_o  output  32  delivered instruction, to IF/DC instruction input
pipe_en  output  1  IF/DC load enable
flush  output  1  IF/DC flush (clears instruction, holds npc)
halted  output  1  fetch stopped on HALT
fetch_count  output  32  number of instructions accepted into IF/DC

Behaviour:
- Reset (nRST is asynchronous and active-low; CLK is the clock):
  - pc=PC_INIT, state=FETCH, tgt_r=0, fetch_count=0.
  - Outputs during reset: iREN=0, pipe_en=0, flush=0, halted=0.
- Address: imemaddr = pc in FETCH and HALTED; pc is always word aligned, with bits [1:0] forced to 0 on redirect load.
- Combinational outputs: npc_o = pc+4 (modulo 2^32, wraps 32'hFFFF_FFFC -> 0); imemload_o = imemload.
- States: FETCH, DRAIN, HALTED.
- FETCH:
  - iREN=1.
  - Accept condition: ihit & !stall & !redirect_valid. On accept: pipe_en=1, pc<=pc+4, fetch_count+1.
    - If imemload[31:26]==HALT_OP, also go to HALTED (the HALT word itself is delivered).
  - ihit & stall & !redirect_valid: pipe_en=0, pc held; the same address is re-presented and the hit repeats.
  - redirect_valid with ihit=1: flush=1, pipe_en=0, fetched word discarded, pc<=redirect_pc, stay in FETCH.
  - redirect_valid with ihit=0 (miss outstanding): flush=1, pipe_en=0, tgt_r<=redirect_pc, go to DRAIN; pc and imemaddr held so the cache fill completes on the old address.
  - Redirect has priority over stall and over HALT detection.
- DRAIN:
  - iREN=1, imemaddr=pc (old), pipe_en=0.
  - A further redirect_valid overwrites tgt_r and asserts flush again.
  - On ihit: word discarded, pc<=tgt_r (or redirect_pc if a redirect arrives the same cycle), go to FETCH.
  - stall is ignored in DRAIN.
- HALTED:
  - iREN=0, pipe_en=0, halted=1, pc held.
  - redirect_valid (a branch older than HALT): flush=1, pc<=redirect_pc, go to FETCH, halted=0 next cycle.
- flush = redirect_valid in every state; it is never asserted otherwise.
- fetch_count wraps at 2^32.
- Latency: a hit in cycle N appears at the IF/DC outputs after edge N+1; the new pc is driven on imemaddr in cycle N+1.

Decomposition:
- cpu_types_pkg gets:
  - word_t (32-bit)
  - fetch_state_t enum {FETCH, DRAIN, HALTED}
  - HALT opcode constant (the parameter defaults from it)
- Single module; no sub-module needed.
- Port grouping into stage_if is done as a new fetch modport, matching the existing stage interface; flat ports are listed above for clarity.

Test Plan:
- Reset with PC_INIT=0, then ihit=1 every cycle with words 0x20010001, 0x20020002 -> imemaddr 0,4,8; npc_o 4,8; pipe_en=1; fetch_count=2.
- stall=1 for 3 cycles with ihit=1 at pc=0x8 -> pc stays 0x8, pipe_en=0; on release, accepted with npc_o=0xC.
- redirect_valid, redirect_pc=0x40, with ihit=1 at pc=0x10 -> flush=1, pipe_en=0; next imemaddr=0x40; word at 0x10 never delivered.
- ihit=0 at pc=0x20, redirect to 0x80, ihit after 4 cycles, then a second redirect to 0x90 during the wait -> imemaddr stays 0x20 until the hit, then 0x90; two flush pulses; pipe_en=0 throughout.
- Fetch 0xFC000000 (HALT) -> delivered with pipe_en=1, then halted=1, iREN=0; redirect to 0x100 -> iREN=1, imemaddr=0x100.
- pc=0xFFFF_FFFC with a hit -> npc_o=0, pc wraps to 0; nRST asserted mid-DRAIN -> state FETCH, pc=PC_INIT immediately.
